button_debounce: RTL

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

---
 rtl/button_debounce_pkg.sv | 19 +
 rtl/button_debounce_cell.sv | 47 ++++
 rtl/button_debounce.sv | 92 +++++++++
 3 files changed

// File: rtl/button_debounce_pkg.sv
// ============================================================================
// button_debounce_pkg: shared CSR map and field widths for button_debounce
// Revision: 1.0
// ============================================================================
`default_nettype none

package button_debounce_pkg;

    localparam int C_NUM_BUTTONS = 4;
    localparam int C_COUNT_WIDTH = 8;

    localparam logic [3:0] C_ADDR_STATUS  = 4'h0;
    localparam logic [3:0] C_ADDR_PENDING = 4'h1;
    localparam logic [3:0] C_ADDR_COUNT   = 4'h2;
    localparam logic [3:0] C_ADDR_MASK    = 4'h3;

endpackage

`default_nettype wire

// File: rtl/button_debounce_cell.sv
// ============================================================================
// debounce_cell: per-button synchronizer, stability counter, level, press pulse
// Revision: 1.0
// ============================================================================
`default_nettype none

module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b00;
            r_count <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
            press  <= 1'b0;
            if (r_sync[1] == level) begin
                r_count <= '0;
            end else if (r_count == C_MAX) begin
                // Mismatch has lasted DEBOUNCE_CYCLES samples: accept it.
                level   <= ~level;
                press   <= ~level;
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
// button_debounce: four debounced buttons with status/pending/count/mask CSRs
// Revision: 1.0
// ============================================================================
`default_nettype none

module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn_raw,
    output logic [3:0]  buttons,
    output logic [3:0]  press,
    output logic        irq,
    input  logic [3:0]  csr_addr,
    input  logic [31:0] csr_wdata,
    input  logic        csr_we,
    output logic [31:0] csr_rdata
);

    logic [C_NUM_BUTTONS-1:0]                    r_pending;
    logic [C_NUM_BUTTONS-1:0]                    r_mask;
    logic [C_NUM_BUTTONS-1:0][C_COUNT_WIDTH-1:0] r_count;

    logic w_wr_pending;
    logic w_wr_count;
    logic w_wr_mask;
    logic w_unused_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_BUTTONS; gi++) begin : g_cell
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_cell (
                .clk    (clk),
                .rst    (rst),
                .btn_raw(btn_raw[gi]),
                .level  (buttons[gi]),
                .press  (press[gi])
            );
        end
    endgenerate

    assign w_wr_pending   = csr_we && (csr_addr == C_ADDR_PENDING);
    assign w_wr_count     = csr_we && (csr_addr == C_ADDR_COUNT);
    assign w_wr_mask      = csr_we && (csr_addr == C_ADDR_MASK);
    assign w_unused_wdata = ^csr_wdata[31:4];

    assign irq = |(r_pending & r_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_count   <= '0;
        end else begin
            // A new press wins over a same-cycle W1C clear.
            r_pending <= (r_pending & ~(w_wr_pending ? csr_wdata[3:0] : 4'h0)) | press;
            if (w_wr_mask) begin
                r_mask <= csr_wdata[3:0];
            end
            for (int i = 0; i < C_NUM_BUTTONS; i++) begin
                if (w_wr_count) begin
                    r_count[i] <= {{(C_COUNT_WIDTH-1){1'b0}}, press[i]};
                end else if (press[i]) begin
                    r_count[i] <= r_count[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csr_rdata <= '0;
        end else begin
            case (csr_addr)
                C_ADDR_STATUS:  csr_rdata <= {28'h0, buttons};
                C_ADDR_PENDING: csr_rdata <= {28'h0, r_pending};
                C_ADDR_COUNT:   csr_rdata <= r_count;
                C_ADDR_MASK:    csr_rdata <= {28'h0, r_mask};
                default:        csr_rdata <= '0;
            endcase
        end
    end

endmodule

`default_nettype wire
